// File: rtl/alu_gate_ctrl_pkg.sv
// alu_gate_ctrl_pkg
//   Shared definitions for the ALU clock-gate controller:
//   - gate_state_t : FSM state encoding
//   - FUN_WIDTH_DEF / DATA_WIDTH_DEF : default parameter values
//   - cnt_width()  : width of the shared hold/timeout down-counter
package alu_gate_ctrl_pkg;

   localparam int FUN_WIDTH_DEF  = 4;
   localparam int DATA_WIDTH_DEF = 8;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAKE = 3'd1,
      ST_EXEC = 3'd2,
      ST_WAIT = 3'd3,
      ST_RESP = 3'd4,
      ST_HOLD = 3'd5
   } gate_state_t;

   // Enough bits to hold the larger of the two load values.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/alu_gate_ctrl_counter.sv
// gate_cycle_counter
//   Loadable down-counter shared by the HOLD linger time and the WAIT
//   timeout. The two uses never overlap because they belong to
//   mutually exclusive FSM states.
//   Ports:
//     clk_sys  : clock
//     rst_b    : synchronous active-low reset (count -> 0)
//     clr      : force count to 0 (highest priority after reset)
//     load     : load load_val
//     load_val : value to load
//     dec      : decrement by one, saturating at 0
//     tc       : terminal count, high when the current cycle is the last
//                one of the loaded interval (count <= 1)
module gate_cycle_counter
   import alu_gate_ctrl_pkg::*;
#(
   parameter int WIDTH = 5
) (
   input  logic             clk_sys,
   input  logic             rst_b,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             tc
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk_sys) begin
      if (!rst_b) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - WIDTH'(1);
      end
   end

   // A load of N yields exactly N cycles before tc-driven expiry:
   // N, N-1, ..., 1 (tc high on the cycle holding 1).
   assign tc = (count_q <= WIDTH'(1));

endmodule

// File: rtl/alu_gate_ctrl.sv
// alu_gate_ctrl
//   Sequences the clock gate and start strobe of a multi-cycle ALU.
//   A command wakes the gated ALU clock, issues a one-cycle start,
//   waits (bounded) for the result, presents it with a valid/ready
//   handshake and lingers with the clock running so a back-to-back
//   command can skip the wake-up cycle.
//   Ports:
//     CLK, RST              : clock, synchronous active-low reset
//     CMD_VALID/CMD_FUN     : command request and ALU function
//     CMD_READY             : command accepted when high with CMD_VALID
//     ALU_CLK_EN            : registered enable into the latch-based gate
//     ALU_EN / ALU_FUN      : ALU start strobe and function
//     ALU_OUT/ALU_OUT_VALID : ALU result and its valid
//     RES_DATA/RES_ERR      : captured result, timeout flag
//     RES_VALID/RES_READY   : result handshake
//     BUSY                  : high whenever not IDLE
//
//   state | meaning
//   IDLE  | gate off, waiting for a command
//   WAKE  | gate just enabled, one cycle for the ALU clock to start
//   EXEC  | ALU_EN strobe, timeout counter loaded
//   WAIT  | waiting for ALU_OUT_VALID or timeout
//   RESP  | RES_VALID held until RES_READY
//   HOLD  | gate kept on for HOLD_CYCLES, accepts a command straight to EXEC
module alu_gate_ctrl
   import alu_gate_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int FUN_WIDTH      = FUN_WIDTH_DEF,
   parameter int HOLD_CYCLES    = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    CMD_VALID,
   input  logic [FUN_WIDTH-1:0]    CMD_FUN,
   output logic                    CMD_READY,
   output logic                    ALU_CLK_EN,
   output logic                    ALU_EN,
   output logic [FUN_WIDTH-1:0]    ALU_FUN,
   input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
   input  logic                    ALU_OUT_VALID,
   output logic [2*DATA_WIDTH-1:0] RES_DATA,
   output logic                    RES_ERR,
   output logic                    RES_VALID,
   input  logic                    RES_READY,
   output logic                    BUSY
);

   localparam int               CNT_W        = cnt_width(HOLD_CYCLES, TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES);

   gate_state_t               state_q;
   gate_state_t               state_nxt;
   logic                      clk_en_q;
   logic [FUN_WIDTH-1:0]      fun_q;
   logic [2*DATA_WIDTH-1:0]   res_data_q;
   logic                      res_err_q;

   logic                      fun_ld;
   logic                      cap_ok;
   logic                      cap_to;
   logic                      cnt_clr;
   logic                      cnt_ld;
   logic [CNT_W-1:0]          cnt_val;
   logic                      cnt_dec;
   logic                      cnt_tc;

   gate_cycle_counter #(
      .WIDTH (CNT_W)
   ) u_cnt (
      .clk_sys  (CLK),
      .rst_b    (RST),
      .clr      (cnt_clr),
      .load     (cnt_ld),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .tc       (cnt_tc)
   );

   always_comb begin
      state_nxt = state_q;
      fun_ld    = 1'b0;
      cap_ok    = 1'b0;
      cap_to    = 1'b0;
      cnt_clr   = 1'b0;
      cnt_ld    = 1'b0;
      cnt_val   = '0;
      cnt_dec   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (CMD_VALID) begin
               fun_ld    = 1'b1;
               state_nxt = ST_WAKE;
            end
         end

         ST_WAKE: begin
            state_nxt = ST_EXEC;
         end

         ST_EXEC: begin
            cnt_ld    = 1'b1;
            cnt_val   = TIMEOUT_LOAD;
            state_nxt = ST_WAIT;
         end

         ST_WAIT: begin
            // A result arriving on the expiry cycle is still a good result.
            if (ALU_OUT_VALID) begin
               cap_ok    = 1'b1;
               cnt_clr   = 1'b1;
               state_nxt = ST_RESP;
            end else if (cnt_tc) begin
               cap_to    = 1'b1;
               cnt_clr   = 1'b1;
               state_nxt = ST_RESP;
            end else begin
               cnt_dec = 1'b1;
            end
         end

         ST_RESP: begin
            if (RES_READY) begin
               if (HOLD_CYCLES == 0) begin
                  state_nxt = ST_IDLE;
               end else begin
                  cnt_ld    = 1'b1;
                  cnt_val   = HOLD_LOAD;
                  state_nxt = ST_HOLD;
               end
            end
         end

         ST_HOLD: begin
            // New command beats linger expiry so the gate never blinks off.
            if (CMD_VALID) begin
               fun_ld    = 1'b1;
               cnt_clr   = 1'b1;
               state_nxt = ST_EXEC;
            end else begin
               cnt_dec = 1'b1;
               if (cnt_tc) begin
                  state_nxt = ST_IDLE;
               end
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q    <= ST_IDLE;
         clk_en_q   <= 1'b0;
         fun_q      <= '0;
         res_data_q <= '0;
         res_err_q  <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         // Registered from the next state so the gate enable is a clean
         // flop output, never a decode of multiple changing state bits.
         clk_en_q <= (state_nxt != ST_IDLE);
         if (fun_ld) begin
            fun_q <= CMD_FUN;
         end
         if (cap_ok) begin
            res_data_q <= ALU_OUT;
            res_err_q  <= 1'b0;
         end else if (cap_to) begin
            res_data_q <= '0;
            res_err_q  <= 1'b1;
         end
      end
   end

   assign CMD_READY  = (state_q == ST_IDLE) || (state_q == ST_HOLD);
   assign ALU_CLK_EN = clk_en_q;
   assign ALU_EN     = (state_q == ST_EXEC);
   assign ALU_FUN    = fun_q;
   assign RES_DATA   = res_data_q;
   assign RES_ERR    = res_err_q;
   assign RES_VALID  = (state_q == ST_RESP);
   assign BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_gate_ctrl.sv
module tb_alu_gate_ctrl;

   typedef struct {
      logic [15:0] data;
      logic        err;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        CMD_VALID = 1'b0;
   logic [3:0]  CMD_FUN = '0;
   logic        CMD_READY;
   logic        ALU_CLK_EN;
   logic        ALU_EN;
   logic [3:0]  ALU_FUN;
   logic [15:0] ALU_OUT = '0;
   logic        ALU_OUT_VALID = 1'b0;
   logic [15:0] RES_DATA;
   logic        RES_ERR;
   logic        RES_VALID;
   logic        RES_READY = 1'b0;
   logic        BUSY;

   logic        z_rst = 1'b0;
   logic        z_cmd_valid = 1'b0;
   logic [3:0]  z_cmd_fun = '0;
   logic        z_cmd_ready;
   logic        z_clk_en;
   logic        z_alu_en;
   logic [3:0]  z_alu_fun;
   logic [15:0] z_alu_out = '0;
   logic        z_alu_out_valid = 1'b0;
   logic [15:0] z_res_data;
   logic        z_res_err;
   logic        z_res_valid;
   logic        z_res_ready = 1'b0;
   logic        z_busy;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   always #5 CLK = ~CLK;

   alu_gate_ctrl #(
      .DATA_WIDTH(8), .FUN_WIDTH(4), .HOLD_CYCLES(4), .TIMEOUT_CYCLES(16)
   ) dut (
      .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_FUN(CMD_FUN),
      .CMD_READY(CMD_READY), .ALU_CLK_EN(ALU_CLK_EN), .ALU_EN(ALU_EN),
      .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
      .RES_DATA(RES_DATA), .RES_ERR(RES_ERR), .RES_VALID(RES_VALID),
      .RES_READY(RES_READY), .BUSY(BUSY)
   );

   alu_gate_ctrl #(
      .DATA_WIDTH(8), .FUN_WIDTH(4), .HOLD_CYCLES(0), .TIMEOUT_CYCLES(16)
   ) dut_h0 (
      .CLK(CLK), .RST(z_rst), .CMD_VALID(z_cmd_valid), .CMD_FUN(z_cmd_fun),
      .CMD_READY(z_cmd_ready), .ALU_CLK_EN(z_clk_en), .ALU_EN(z_alu_en),
      .ALU_FUN(z_alu_fun), .ALU_OUT(z_alu_out), .ALU_OUT_VALID(z_alu_out_valid),
      .RES_DATA(z_res_data), .RES_ERR(z_res_err), .RES_VALID(z_res_valid),
      .RES_READY(z_res_ready), .BUSY(z_busy)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic issue_cmd(input logic [3:0] fun);
      CMD_VALID = 1'b1;
      CMD_FUN   = fun;
      step();
      CMD_VALID = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (!BUSY) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   // Waits for RES_VALID, samples the result, then completes the handshake.
   task automatic take_result(output logic [15:0] d, output logic e, output bit ok);
      ok = 1'b0;
      d  = '0;
      e  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (RES_VALID) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      if (ok) begin
         d = RES_DATA;
         e = RES_ERR;
         RES_READY = 1'b1;
         step();
         RES_READY = 1'b0;
      end
   endtask

   task automatic test_reset();
      RST = 1'b0;
      step();
      step();
      checks++;
      if ({CMD_READY, ALU_CLK_EN, ALU_EN, RES_VALID, RES_ERR, BUSY} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 100000",
                  {CMD_READY, ALU_CLK_EN, ALU_EN, RES_VALID, RES_ERR, BUSY});
      end
      checks++;
      if (ALU_FUN !== 4'h0) begin
         errors++;
         $display("FAIL reset_alu_fun: got %h expected 0", ALU_FUN);
      end
      checks++;
      if (RES_DATA !== 16'h0000) begin
         errors++;
         $display("FAIL reset_res_data: got %h expected 0000", RES_DATA);
      end
      RST = 1'b1;
      step();
   endtask

   task automatic test_idle_cmd();
      logic [15:0] d;
      logic        e;
      bit          ok;
      exp_t        x;
      issue_cmd(4'h2);
      checks++;
      if ({ALU_CLK_EN, ALU_EN, BUSY, CMD_READY} !== 4'b1010 || ALU_FUN !== 4'h2) begin
         errors++;
         $display("FAIL idle_wake: got en/alu_en/busy/rdy=%b fun=%h expected 1010 fun=2",
                  {ALU_CLK_EN, ALU_EN, BUSY, CMD_READY}, ALU_FUN);
      end
      step();
      checks++;
      if (ALU_EN !== 1'b1) begin
         errors++;
         $display("FAIL idle_exec_strobe: got %b expected 1", ALU_EN);
      end
      step();
      checks++;
      if (ALU_EN !== 1'b0 || RES_VALID !== 1'b0) begin
         errors++;
         $display("FAIL idle_wait1: got alu_en=%b res_valid=%b expected 0 0", ALU_EN, RES_VALID);
      end
      step();
      ALU_OUT_VALID = 1'b1;
      ALU_OUT       = 16'h00A5;
      sb.push_back('{data: 16'h00A5, err: 1'b0});
      step();
      ALU_OUT_VALID = 1'b0;
      take_result(d, e, ok);
      checks++;
      if (!ok || sb.size() == 0) begin
         errors++;
         $display("FAIL idle_result: got no result expected RES_VALID");
      end else begin
         x = sb.pop_front();
         if (d !== x.data || e !== x.err) begin
            errors++;
            $display("FAIL idle_result: got %h/%b expected %h/%b", d, e, x.data, x.err);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] d;
      logic        e;
      bit          ok;
      exp_t        x;
      wait_idle(ok);
      issue_cmd(4'h3);
      step();
      step();
      ALU_OUT_VALID = 1'b1;
      ALU_OUT       = 16'h1234;
      sb.push_back('{data: 16'h1234, err: 1'b0});
      step();
      ALU_OUT_VALID = 1'b0;
      take_result(d, e, ok);
      checks++;
      x = (sb.size() != 0) ? sb.pop_front() : '{data: 16'hxxxx, err: 1'bx};
      if (!ok || d !== x.data || e !== x.err) begin
         errors++;
         $display("FAIL b2b_first_result: got %h/%b ok=%0d expected %h/%b", d, e, ok, x.data, x.err);
      end
      step();
      checks++;
      if (CMD_READY !== 1'b1 || ALU_CLK_EN !== 1'b1) begin
         errors++;
         $display("FAIL b2b_hold_ready: got rdy=%b en=%b expected 1 1", CMD_READY, ALU_CLK_EN);
      end
      issue_cmd(4'h7);
      checks++;
      if (ALU_EN !== 1'b1 || ALU_FUN !== 4'h7 || ALU_CLK_EN !== 1'b1) begin
         errors++;
         $display("FAIL b2b_skip_wake: got alu_en=%b fun=%h en=%b expected 1 7 1", ALU_EN, ALU_FUN, ALU_CLK_EN);
      end
      step();
      ALU_OUT_VALID = 1'b1;
      ALU_OUT       = 16'hBEEF;
      sb.push_back('{data: 16'hBEEF, err: 1'b0});
      step();
      ALU_OUT_VALID = 1'b0;
      take_result(d, e, ok);
      checks++;
      x = (sb.size() != 0) ? sb.pop_front() : '{data: 16'hxxxx, err: 1'bx};
      if (!ok || d !== x.data || e !== x.err) begin
         errors++;
         $display("FAIL b2b_second_result: got %h/%b ok=%0d expected %h/%b", d, e, ok, x.data, x.err);
      end
      step();
      step();
      step();
      checks++;
      if (ALU_CLK_EN !== 1'b1 || CMD_READY !== 1'b1) begin
         errors++;
         $display("FAIL b2b_last_hold: got en=%b rdy=%b expected 1 1", ALU_CLK_EN, CMD_READY);
      end
      issue_cmd(4'h9);
      checks++;
      if (ALU_EN !== 1'b1 || ALU_FUN !== 4'h9 || ALU_CLK_EN !== 1'b1) begin
         errors++;
         $display("FAIL b2b_expiry_cmd: got alu_en=%b fun=%h en=%b expected 1 9 1", ALU_EN, ALU_FUN, ALU_CLK_EN);
      end
      step();
      ALU_OUT_VALID = 1'b1;
      ALU_OUT       = 16'h0009;
      sb.push_back('{data: 16'h0009, err: 1'b0});
      step();
      ALU_OUT_VALID = 1'b0;
      take_result(d, e, ok);
      checks++;
      x = (sb.size() != 0) ? sb.pop_front() : '{data: 16'hxxxx, err: 1'bx};
      if (!ok || d !== x.data || e !== x.err) begin
         errors++;
         $display("FAIL b2b_third_result: got %h/%b ok=%0d expected %h/%b", d, e, ok, x.data, x.err);
      end
   endtask

   task automatic test_timeout();
      logic [15:0] d;
      logic        e;
      bit          ok;
      exp_t        x;
      wait_idle(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL timeout_start_idle: got busy=%b expected 0", BUSY);
      end
      issue_cmd(4'h5);
      step();
      step();
      sb.push_back('{data: 16'h0000, err: 1'b1});
      for (int i = 0; i < 15; i++) step();
      checks++;
      if (RES_VALID !== 1'b0 || BUSY !== 1'b1) begin
         errors++;
         $display("FAIL timeout_early: got res_valid=%b busy=%b expected 0 1", RES_VALID, BUSY);
      end
      step();
      checks++;
      if (RES_VALID !== 1'b1) begin
         errors++;
         $display("FAIL timeout_at_16: got res_valid=%b expected 1", RES_VALID);
      end
      take_result(d, e, ok);
      checks++;
      x = (sb.size() != 0) ? sb.pop_front() : '{data: 16'hxxxx, err: 1'bx};
      if (!ok || d !== x.data || e !== x.err) begin
         errors++;
         $display("FAIL timeout_result: got %h/%b ok=%0d expected %h/%b", d, e, ok, x.data, x.err);
      end

      wait_idle(ok);
      issue_cmd(4'h6);
      step();
      step();
      for (int i = 0; i < 15; i++) step();
      ALU_OUT_VALID = 1'b1;
      ALU_OUT       = 16'h0F0F;
      sb.push_back('{data: 16'h0F0F, err: 1'b0});
      step();
      ALU_OUT_VALID = 1'b0;
      take_result(d, e, ok);
      checks++;
      x = (sb.size() != 0) ? sb.pop_front() : '{data: 16'hxxxx, err: 1'bx};
      if (!ok || d !== x.data || e !== x.err) begin
         errors++;
         $display("FAIL timeout_valid_wins: got %h/%b ok=%0d expected %h/%b", d, e, ok, x.data, x.err);
      end
   endtask

   task automatic test_stall();
      logic [15:0] d;
      logic        e;
      bit          ok;
      exp_t        x;
      wait_idle(ok);
      issue_cmd(4'h1);
      step();
      step();
      ALU_OUT_VALID = 1'b1;
      ALU_OUT       = 16'h5A5A;
      sb.push_back('{data: 16'h5A5A, err: 1'b0});
      step();
      ALU_OUT_VALID = 1'b0;
      x = (sb.size() != 0) ? sb[0] : '{data: 16'hxxxx, err: 1'bx};
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (RES_VALID !== 1'b1 || RES_DATA !== x.data || RES_ERR !== x.err) begin
            errors++;
            $display("FAIL stall_stable[%0d]: got v=%b %h/%b expected 1 %h/%b",
                     i, RES_VALID, RES_DATA, RES_ERR, x.data, x.err);
         end
         // Stray ALU result outside WAIT must not disturb the held result.
         if (i == 3) begin
            ALU_OUT_VALID = 1'b1;
            ALU_OUT       = 16'hFFFF;
         end
         step();
         ALU_OUT_VALID = 1'b0;
      end
      take_result(d, e, ok);
      checks++;
      x = (sb.size() != 0) ? sb.pop_front() : '{data: 16'hxxxx, err: 1'bx};
      if (!ok || d !== x.data || e !== x.err) begin
         errors++;
         $display("FAIL stall_result: got %h/%b ok=%0d expected %h/%b", d, e, ok, x.data, x.err);
      end
      for (int i = 1; i <= 3; i++) begin
         step();
         checks++;
         if (ALU_CLK_EN !== 1'b1 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got en=%b busy=%b expected 1 1", i, ALU_CLK_EN, BUSY);
         end
      end
      step();
      checks++;
      if (ALU_CLK_EN !== 1'b0 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL stall_hold_end: got en=%b busy=%b expected 0 0", ALU_CLK_EN, BUSY);
      end
   endtask

   task automatic test_reset_mid_wait();
      bit ok;
      wait_idle(ok);
      issue_cmd(4'h4);
      step();
      step();
      step();
      RST = 1'b0;
      step();
      RST = 1'b1;
      checks++;
      if ({BUSY, ALU_CLK_EN, RES_VALID, CMD_READY} !== 4'b0001 || RES_DATA !== 16'h0000) begin
         errors++;
         $display("FAIL rst_wait: got busy/en/v/rdy=%b data=%h expected 0001 0000",
                  {BUSY, ALU_CLK_EN, RES_VALID, CMD_READY}, RES_DATA);
      end
      ALU_OUT_VALID = 1'b1;
      ALU_OUT       = 16'h7777;
      step();
      step();
      ALU_OUT_VALID = 1'b0;
      checks++;
      if (BUSY !== 1'b0 || RES_VALID !== 1'b0 || RES_DATA !== 16'h0000) begin
         errors++;
         $display("FAIL rst_late_valid: got busy=%b v=%b data=%h expected 0 0 0000", BUSY, RES_VALID, RES_DATA);
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drained: got %0d pending expected 0", sb.size());
      end
   endtask

   task automatic test_hold_zero();
      exp_t x;
      z_rst = 1'b0;
      step();
      step();
      z_rst = 1'b1;
      z_cmd_valid = 1'b1;
      z_cmd_fun   = 4'hA;
      step();
      z_cmd_valid = 1'b0;
      step();
      checks++;
      if (z_alu_en !== 1'b1 || z_alu_fun !== 4'hA || z_clk_en !== 1'b1) begin
         errors++;
         $display("FAIL h0_exec: got alu_en=%b fun=%h en=%b expected 1 a 1", z_alu_en, z_alu_fun, z_clk_en);
      end
      step();
      z_alu_out_valid = 1'b1;
      z_alu_out       = 16'hC3C3;
      sb.push_back('{data: 16'hC3C3, err: 1'b0});
      step();
      z_alu_out_valid = 1'b0;
      checks++;
      x = (sb.size() != 0) ? sb.pop_front() : '{data: 16'hxxxx, err: 1'bx};
      if (z_res_valid !== 1'b1 || z_res_data !== x.data || z_res_err !== x.err) begin
         errors++;
         $display("FAIL h0_result: got v=%b %h/%b expected 1 %h/%b", z_res_valid, z_res_data, z_res_err, x.data, x.err);
      end
      z_res_ready = 1'b1;
      step();
      z_res_ready = 1'b0;
      checks++;
      if ({z_busy, z_clk_en, z_cmd_ready, z_res_valid} !== 4'b0010) begin
         errors++;
         $display("FAIL h0_idle_after_resp: got busy/en/rdy/v=%b expected 0010",
                  {z_busy, z_clk_en, z_cmd_ready, z_res_valid});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_idle_cmd();
      test_back_to_back();
      test_timeout();
      test_stall();
      test_reset_mid_wait();
      test_hold_zero();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
